// File: rtl/manquehuito_pkg.sv
// Shared types for the writeback side of the operand-select datapath.
// Destination encodings, writeback FSM states and flag bit positions.
package manquehuito_pkg;

  typedef enum logic [1:0] {
    DST_NONE = 2'b00,
    DST_REGA = 2'b01,
    DST_REGB = 2'b10,
    DST_MEM  = 2'b11
  } dst_sel_e;

  typedef enum logic [0:0] {
    WB_IDLE   = 1'b0,
    WB_MEM_WR = 1'b1
  } wb_state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/mem_wr_port.sv
// Data-memory write port: valid/ready handshake with address/data hold,
// saturating timeout counter and sticky timeout error.
module mem_wr_port
  import manquehuito_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              err_clr_i,
  input  logic              mem_wready_i,
  output logic              mem_wvalid_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int CNT_W =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit HAS_TO = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  wb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic             err_q;
  logic             in_wr;
  logic             hs;
  logic             tmo;

  assign in_wr = (state_q == WB_MEM_WR);
  assign hs    = in_wr && mem_wready_i;
  assign tmo   = in_wr && !mem_wready_i
              && HAS_TO && (cnt_q == TO_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= WB_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE:   if (start_i) state_d = WB_MEM_WR;
      WB_MEM_WR: if (hs || tmo) state_d = WB_IDLE;
      default:   state_d = WB_IDLE;
    endcase
  end

  always_comb begin
    mem_wvalid_o = in_wr;
    busy_o       = (state_q != WB_IDLE);
    done_o       = hs;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (start_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
        cnt_q  <= '0;
      end else if (in_wr && !mem_wready_i && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // a timeout landing with a clear request keeps the error visible
      if (tmo)            err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
    end
  end

  assign mem_waddr_o = addr_q;
  assign mem_wdata_o = data_q;
  assign err_o       = err_q;

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: routes ALU results to RegA/RegB/memory and owns
// the register and flag storage that feeds the operand muxes.
module reg_writeback
  import manquehuito_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int FLAG_W      = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [1:0]        dst_sel_i,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic              flags_we_i,
  input  logic [FLAG_W-1:0] alu_flags_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] reg_a_o,
  output logic [DATA_W-1:0] reg_b_o,
  output logic [FLAG_W-1:0] flags_o,
  output logic              mem_wvalid_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_wready_i,
  output logic              busy_o,
  output logic              wr_done_o,
  output logic              err_o
);

  dst_sel_e          dst;
  logic              accept;
  logic              mem_start;
  logic              mem_done;
  logic [DATA_W-1:0] reg_a_q;
  logic [DATA_W-1:0] reg_b_q;
  logic [FLAG_W-1:0] flags_q;
  logic              done_q;

  assign dst       = dst_sel_e'(dst_sel_i);
  assign accept    = wr_en_i && !busy_o;
  assign mem_start = accept && (dst == DST_MEM);

  mem_wr_port #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wr_port (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (mem_start),
    .addr_i       (mem_addr_i),
    .data_i       (alu_res_i),
    .err_clr_i    (err_clr_i),
    .mem_wready_i (mem_wready_i),
    .mem_wvalid_o (mem_wvalid_o),
    .mem_waddr_o  (mem_waddr_o),
    .mem_wdata_o  (mem_wdata_o),
    .busy_o       (busy_o),
    .done_o       (mem_done),
    .err_o        (err_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      reg_a_q <= '0;
      reg_b_q <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (accept && dst != DST_MEM) || mem_done;
      if (accept && dst == DST_REGA) reg_a_q <= alu_res_i;
      if (accept && dst == DST_REGB) reg_b_q <= alu_res_i;
      if (accept && flags_we_i)      flags_q <= alu_flags_i;
    end
  end

  assign reg_a_o   = reg_a_q;
  assign reg_b_o   = reg_b_q;
  assign flags_o   = flags_q;
  assign wr_done_o = done_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: expected register and memory
// results are queued by the stimulus and checked by monitors.
module tb_reg_writeback;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] dst;
  logic [7:0] res;
  logic [7:0] addr;
  logic       fwe;
  logic [3:0] flg;
  logic       err_clr;
  logic [7:0] reg_a;
  logic [7:0] reg_b;
  logic [3:0] flags;
  logic       wvalid;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic       wready;
  logic       busy;
  logic       done;
  logic       err;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] f;
  } reg_exp_t;

  typedef struct packed {
    logic [7:0] ad;
    logic [7:0] d;
  } mem_exp_t;

  reg_exp_t rq[$];
  mem_exp_t mq[$];
  int n_chk  = 0;
  int n_fail = 0;
  int n_done_exp = 0;
  int n_done_seen = 0;

  reg_writeback #(.MEM_TIMEOUT(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wr_en_i      (wr_en),
    .dst_sel_i    (dst),
    .alu_res_i    (res),
    .mem_addr_i   (addr),
    .flags_we_i   (fwe),
    .alu_flags_i  (flg),
    .err_clr_i    (err_clr),
    .reg_a_o      (reg_a),
    .reg_b_o      (reg_b),
    .flags_o      (flags),
    .mem_wvalid_o (wvalid),
    .mem_waddr_o  (waddr),
    .mem_wdata_o  (wdata),
    .mem_wready_i (wready),
    .busy_o       (busy),
    .wr_done_o    (done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_reg(input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] f);
    reg_exp_t e;
    e.a = a; e.b = b; e.f = f;
    rq.push_back(e);
    n_done_exp++;
  endtask

  always @(negedge clk) begin
    reg_exp_t e;
    if (rst_n && done) begin
      n_done_seen++;
      if (rq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = rq.pop_front();
        chk("done_reg_a", reg_a, e.a);
        chk("done_reg_b", reg_b, e.b);
        chk("done_flags", flags, e.f);
      end
    end
  end

  always @(negedge clk) begin
    mem_exp_t m;
    if (rst_n && wvalid && wready) begin
      if (mq.size() == 0) begin
        chk("unexpected_mem_hs", 32'd1, 32'd0);
      end else begin
        m = mq.pop_front();
        chk("hs_addr", waddr, m.ad);
        chk("hs_data", wdata, m.d);
      end
    end
  end

  task automatic mem_req(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; dst = 2'b11; addr = a; res = d; fwe = 1'b0;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; dst = 2'b00; res = '0; addr = '0;
    fwe = 1'b0; flg = '0; err_clr = 1'b0; wready = 1'b0;
    step();
    step();
    chk("rst_reg_a", reg_a, 0);
    chk("rst_reg_b", reg_b, 0);
    chk("rst_flags", flags, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step();

    // RegA write with flags
    wr_en = 1'b1; dst = 2'b01; res = 8'hA5; fwe = 1'b1; flg = 4'b1000;
    push_reg(8'hA5, 8'h00, 4'b1000);
    step();
    wr_en = 1'b0; fwe = 1'b0;
    chk("t1_done", done, 1);
    step();
    chk("t1_done_pulse", done, 0);

    // memory write, ready after 3 cycles, RegB request ignored while busy
    mq.push_back({8'h3C, 8'h7E});
    push_reg(8'hA5, 8'h00, 4'b1000);
    mem_req(8'h3C, 8'h7E);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_valid", wvalid, 1);
      chk("t2_busy", busy, 1);
      chk("t2_addr", waddr, 8'h3C);
      chk("t2_data", wdata, 8'h7E);
      chk("t2_no_done", done, 0);
      if (i == 4) begin
        wr_en = 1'b0; wready = 1'b1;
      end else begin
        wr_en = 1'b1; dst = 2'b10; res = 8'h11;
      end
      step();
    end
    wready = 1'b0; wr_en = 1'b0;
    chk("t2_valid_low", wvalid, 0);
    chk("t2_busy_low", busy, 0);
    chk("t2_err", err, 0);
    chk("t2_reg_b_kept", reg_b, 8'h00);
    step();

    // back-to-back RegB then no-destination flag update
    wr_en = 1'b1; dst = 2'b10; res = 8'h5A; fwe = 1'b0;
    push_reg(8'hA5, 8'h5A, 4'b1000);
    step();
    dst = 2'b00; res = 8'hFF; fwe = 1'b1; flg = 4'b0011;
    push_reg(8'hA5, 8'h5A, 4'b0011);
    step();
    wr_en = 1'b0; fwe = 1'b0;
    step();

    // timeout: ready never asserted
    mem_req(8'h10, 8'h22);
    for (int i = 1; i <= 4; i++) begin
      chk("t4_valid", wvalid, 1);
      step();
    end
    chk("t4_valid_low", wvalid, 0);
    chk("t4_busy_low", busy, 0);
    chk("t4_err", err, 1);
    chk("t4_no_done", done, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4_err_clr", err, 0);

    // timeout coinciding with clear: error still set
    mem_req(8'h20, 8'h33);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) err_clr = 1'b1;
      step();
    end
    chk("t4b_err_wins", err, 1);
    step();
    err_clr = 1'b0;
    chk("t4b_err_cleared", err, 0);

    // ready exactly on the timeout cycle
    mq.push_back({8'h44, 8'h99});
    push_reg(8'hA5, 8'h5A, 4'b0011);
    mem_req(8'h44, 8'h99);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) wready = 1'b1;
      step();
    end
    wready = 1'b0;
    chk("t5_done", done, 1);
    chk("t5_err", err, 0);
    chk("t5_valid_low", wvalid, 0);

    // reset while a write is outstanding
    mem_req(8'h55, 8'h66);
    chk("t6_valid", wvalid, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_reg_a", reg_a, 0);
    chk("t6_reg_b", reg_b, 0);
    chk("t6_flags", flags, 0);
    chk("t6_valid", wvalid, 0);
    chk("t6_waddr", waddr, 0);
    chk("t6_wdata", wdata, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    step();
    chk("t6_done_after", done, 0);

    // normal operation resumes
    wr_en = 1'b1; dst = 2'b01; res = 8'hC3;
    push_reg(8'hC3, 8'h00, 4'b0000);
    step();
    wr_en = 1'b0;
    step();
    step();

    chk("reg_q_empty", rq.size(), 0);
    chk("mem_q_empty", mq.size(), 0);
    chk("done_count", n_done_seen, n_done_exp);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
